// File: rtl/uiudp_tx.sv
// rtl/uiudp_tx.sv - UDP transmit framer feeding uiip_layer's UDP port
// Header is emitted from latched ports/length; payload is pulled from a show-ahead FIFO.
module uiudp_tx #(
  parameter int MAX_PAYLOAD = 1472,
  parameter int REQ_TIMEOUT = 4096
) (
  input  logic        I_udp_clk,
  input  logic        I_udp_reset,
  input  logic [15:0] I_udp_local_port,
  input  logic [15:0] I_udp_dest_port,
  input  logic        I_udp_req,
  input  logic [15:0] I_udp_tdata_len,
  output logic        O_udp_busy,
  output logic        O_udp_tdata_ren,
  input  logic [7:0]  I_udp_tdata,
  output logic        O_udp_err,
  output logic [15:0] O_udp_tx_cnt,
  input  logic        I_ip_udp_tbusy,
  output logic        O_ip_udp_treq,
  output logic        O_ip_udp_tvalid,
  output logic [7:0]  O_ip_udp_tdata,
  output logic [15:0] O_ip_udp_tdata_len
);

  localparam int TW = $clog2(REQ_TIMEOUT) + 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_HDR, S_DATA, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [15:0]   src_q, src_d, dst_q, dst_d;
  logic [15:0]   len_q, len_d, ulen_q, ulen_d;
  logic [15:0]   cnt_q, cnt_d, txc_q, txc_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          armed_q, armed_d;
  logic          treq_q, treq_d, tvalid_q, tvalid_d, ren_q, ren_d;
  logic          err_q, err_d, busy_q, busy_d;
  logic [7:0]    tdata_q, tdata_d;
  logic [7:0]    hbyte;
  logic          len_ok;

  assign len_ok = (I_udp_tdata_len != 16'd0) && (I_udp_tdata_len <= 16'(MAX_PAYLOAD));

  // Header byte selected by the byte counter; checksum bytes stay zero.
  always_comb begin
    hbyte = 8'h00;
    case (cnt_q[2:0])
      3'd0: hbyte = src_q[15:8];
      3'd1: hbyte = src_q[7:0];
      3'd2: hbyte = dst_q[15:8];
      3'd3: hbyte = dst_q[7:0];
      3'd4: hbyte = ulen_q[15:8];
      3'd5: hbyte = ulen_q[7:0];
      default: hbyte = 8'h00;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    ulen_d   = ulen_q;
    cnt_d    = cnt_q;
    txc_d    = txc_q;
    tmo_d    = tmo_q;
    armed_d  = armed_q;
    treq_d   = 1'b0;
    tvalid_d = 1'b0;
    ren_d    = 1'b0;
    err_d    = 1'b0;
    tdata_d  = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (I_udp_req) begin
          if (len_ok) begin
            src_d   = I_udp_local_port;
            dst_d   = I_udp_dest_port;
            len_d   = I_udp_tdata_len;
            ulen_d  = I_udp_tdata_len + 16'd8;
            cnt_d   = 16'd0;
            tmo_d   = '0;
            armed_d = 1'b0;
            treq_d  = 1'b1;
            state_d = S_REQ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        // A busy level left over from the previous packet is not a grant until it has dropped.
        if (!I_ip_udp_tbusy) armed_d = 1'b1;
        if (I_ip_udp_tbusy && armed_q) begin
          tvalid_d = 1'b1;
          tdata_d  = hbyte;
          cnt_d    = 16'd1;
          state_d  = S_HDR;
        end else if (tmo_q == TW'(REQ_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          treq_d = 1'b1;
          tmo_d  = tmo_q + TW'(1);
        end
      end
      S_HDR: begin
        tvalid_d = 1'b1;
        tdata_d  = hbyte;
        if (cnt_q == 16'd7) begin
          cnt_d   = 16'd0;
          ren_d   = 1'b1;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        tvalid_d = 1'b1;
        tdata_d  = I_udp_tdata;
        cnt_d    = cnt_q + 16'd1;
        if (cnt_d == len_q) begin
          txc_d   = txc_q + 16'd1;
          state_d = S_DONE;
        end else begin
          ren_d = 1'b1;
        end
      end
      S_DONE: begin
        if (!I_ip_udp_tbusy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge I_udp_clk or posedge I_udp_reset) begin
    if (I_udp_reset) begin
      state_q  <= S_IDLE;
      src_q    <= 16'd0;
      dst_q    <= 16'd0;
      len_q    <= 16'd0;
      ulen_q   <= 16'd0;
      cnt_q    <= 16'd0;
      txc_q    <= 16'd0;
      tmo_q    <= '0;
      armed_q  <= 1'b0;
      treq_q   <= 1'b0;
      tvalid_q <= 1'b0;
      ren_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      tdata_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      ulen_q   <= ulen_d;
      cnt_q    <= cnt_d;
      txc_q    <= txc_d;
      tmo_q    <= tmo_d;
      armed_q  <= armed_d;
      treq_q   <= treq_d;
      tvalid_q <= tvalid_d;
      ren_q    <= ren_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      tdata_q  <= tdata_d;
    end
  end

  assign O_udp_busy         = busy_q;
  assign O_udp_tdata_ren    = ren_q;
  assign O_udp_err          = err_q;
  assign O_udp_tx_cnt       = txc_q;
  assign O_ip_udp_treq      = treq_q;
  assign O_ip_udp_tvalid    = tvalid_q;
  assign O_ip_udp_tdata     = tdata_q;
  assign O_ip_udp_tdata_len = ulen_q;

endmodule
